// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for a 16-bit data memory.
// Optional byte loads/stores (read-modify-write) when BYTE_ACCESS_EN is defined.
`default_nettype none

module load_store_unit #(
  parameter int READ_LATENCY = 1,
  parameter int MEM_DEPTH    = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        req_byte,
  input  logic        req_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] mem_address,
  output logic [15:0] mem_write_data,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  input  logic [15:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [3:0] LAST_CNT = 4'(READ_LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        is_write;
  logic [15:0] store_word;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        we_q;
  logic        re_q;
  logic        valid_q;
  logic        err_q;
  logic [15:0] rdata_q;

  logic [15:0] req_word;
  logic        req_bad;
  logic        req_is_byte;
  logic        out_of_range;
  logic [15:0] load_data;
  logic [15:0] merge_data;

`ifdef BYTE_ACCESS_EN
  logic       is_byte;
  logic       is_signed;
  logic       byte_sel;
  logic [7:0] sel_byte;

  assign req_is_byte = req_byte;
  assign req_word    = {1'b0, req_addr[15:1]};
  assign req_bad     = !req_byte && req_addr[0];

  assign sel_byte   = byte_sel ? mem_read_data[15:8] : mem_read_data[7:0];
  assign load_data  = !is_byte  ? mem_read_data :
                      is_signed ? {{8{sel_byte[7]}}, sel_byte} : {8'h00, sel_byte};
  assign merge_data = byte_sel ? {store_word[7:0], mem_read_data[7:0]}
                               : {mem_read_data[15:8], store_word[7:0]};
`else
  logic unused_byte_ctl;

  assign req_is_byte     = 1'b0;
  assign req_word        = req_addr;
  assign req_bad         = 1'b0;
  assign load_data       = mem_read_data;
  assign merge_data      = store_word;
  assign unused_byte_ctl = req_byte ^ req_signed;
`endif

  assign out_of_range = 32'(req_word) >= 32'(MEM_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      is_write   <= 1'b0;
      store_word <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
`ifdef BYTE_ACCESS_EN
      is_byte    <= 1'b0;
      is_signed  <= 1'b0;
      byte_sel   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            is_write   <= req_write;
            store_word <= req_wdata;
            cnt        <= '0;
`ifdef BYTE_ACCESS_EN
            is_byte    <= req_byte;
            is_signed  <= req_signed;
            byte_sel   <= req_addr[0];
`endif
            if (out_of_range || req_bad) begin
              state   <= RESP;
              valid_q <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else if (req_write && !req_is_byte) begin
              state   <= WRITE;
              we_q    <= 1'b1;
              addr_q  <= req_word;
              wdata_q <= req_wdata;
            end else begin
              state  <= READ;
              re_q   <= 1'b1;
              addr_q <= req_word;
            end
          end
        end
        READ: begin
          if (cnt == LAST_CNT) begin
            re_q <= 1'b0;
            // Byte stores keep the address and reuse it for the write-back.
            if (is_write) begin
              state   <= WRITE;
              we_q    <= 1'b1;
              wdata_q <= merge_data;
            end else begin
              state   <= RESP;
              addr_q  <= '0;
              valid_q <= 1'b1;
              err_q   <= 1'b0;
              rdata_q <= load_data;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WRITE: begin
          state   <= RESP;
          we_q    <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
          valid_q <= 1'b1;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        RESP: begin
          if (resp_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Gated with rst so no strobe can reach memory during a reset cycle.
  assign mem_address      = rst ? 16'h0000 : addr_q;
  assign mem_write_data   = rst ? 16'h0000 : wdata_q;
  assign mem_write_enable = we_q & ~rst;
  assign mem_read_enable  = re_q & ~rst;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit
// (instance a: READ_LATENCY=1, instance b: READ_LATENCY=3), each with a memory model.
`default_nettype none
`timescale 1ns/1ps

module tb_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_rst, a_req_valid, a_req_ready, a_req_write, a_req_byte, a_req_signed;
  logic [15:0] a_req_addr, a_req_wdata, a_resp_rdata, a_mem_address, a_mem_write_data, a_mem_rdata;
  logic        a_resp_valid, a_resp_ready, a_resp_err, a_mem_we, a_mem_re;

  logic        b_rst, b_req_valid, b_req_ready, b_req_write, b_req_byte, b_req_signed;
  logic [15:0] b_req_addr, b_req_wdata, b_resp_rdata, b_mem_address, b_mem_write_data, b_mem_rdata;
  logic        b_resp_valid, b_resp_ready, b_resp_err, b_mem_we, b_mem_re;

  load_store_unit #(.READ_LATENCY(1), .MEM_DEPTH(512)) dut_a (
    .clk(clk), .rst(a_rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_byte(a_req_byte),
    .req_signed(a_req_signed), .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .mem_address(a_mem_address),
    .mem_write_data(a_mem_write_data), .mem_write_enable(a_mem_we),
    .mem_read_enable(a_mem_re), .mem_read_data(a_mem_rdata)
  );

  load_store_unit #(.READ_LATENCY(3), .MEM_DEPTH(512)) dut_b (
    .clk(clk), .rst(b_rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_byte(b_req_byte),
    .req_signed(b_req_signed), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .mem_address(b_mem_address),
    .mem_write_data(b_mem_write_data), .mem_write_enable(b_mem_we),
    .mem_read_enable(b_mem_re), .mem_read_data(b_mem_rdata)
  );

  // Memory models: combinational read, write on rising edge, strobe counters.
  logic [15:0] mem_a [0:511];
  logic [15:0] mem_b [0:511];
  int a_wr_cnt = 0, a_rd_cnt = 0, b_wr_cnt = 0, b_rd_cnt = 0;

  assign a_mem_rdata = (a_mem_address < 16'd512) ? mem_a[a_mem_address[8:0]] : 16'h0000;
  assign b_mem_rdata = (b_mem_address < 16'd512) ? mem_b[b_mem_address[8:0]] : 16'h0000;

  always @(posedge clk) begin
    if (a_mem_we) begin
      mem_a[a_mem_address[8:0]] <= a_mem_write_data;
      a_wr_cnt <= a_wr_cnt + 1;
    end
    if (a_mem_re) a_rd_cnt <= a_rd_cnt + 1;
    if (b_mem_we) begin
      mem_b[b_mem_address[8:0]] <= b_mem_write_data;
      b_wr_cnt <= b_wr_cnt + 1;
    end
    if (b_mem_re) b_rd_cnt <= b_rd_cnt + 1;
  end

  function automatic logic [15:0] wa(input logic [15:0] w);
`ifdef BYTE_ACCESS_EN
    return {w[14:0], 1'b0};
`else
    return w;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic a_issue(input logic w, input logic [15:0] addr, input logic [15:0] d,
                         input logic b, input logic s);
    a_req_valid = 1'b1; a_req_write = w; a_req_addr = addr;
    a_req_wdata = d; a_req_byte = b; a_req_signed = s;
    tick;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0;
    a_req_wdata = '0; a_req_byte = 1'b0; a_req_signed = 1'b0;
  endtask

  task automatic b_issue(input logic w, input logic [15:0] addr, input logic [15:0] d);
    b_req_valid = 1'b1; b_req_write = w; b_req_addr = addr; b_req_wdata = d;
    tick;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
  endtask

  int wr0, rd0;

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_req_valid = 0; a_req_write = 0; a_req_addr = '0; a_req_wdata = '0;
    a_req_byte = 0; a_req_signed = 0; a_resp_ready = 1;
    b_req_valid = 0; b_req_write = 0; b_req_addr = '0; b_req_wdata = '0;
    b_req_byte = 0; b_req_signed = 0; b_resp_ready = 1;
    tick; tick;
    a_rst = 1'b0; b_rst = 1'b0;

    chk("rst_req_ready", a_req_ready, 1);
    chk("rst_resp_valid", a_resp_valid, 0);
    chk("rst_resp_rdata", a_resp_rdata, 0);
    chk("rst_mem_strobes", {a_mem_we, a_mem_re}, 0);
    chk("rst_mem_address", a_mem_address, 0);

    // Word store 0xBEEF to word 5
    a_issue(1, wa(16'd5), 16'hBEEF, 0, 0);
    chk("st_we", a_mem_we, 1);
    chk("st_addr", a_mem_address, 16'd5);
    chk("st_wdata", a_mem_write_data, 16'hBEEF);
    chk("st_req_ready", a_req_ready, 0);
    chk("st_no_resp_yet", a_resp_valid, 0);
    tick;
    chk("st_we_drop", a_mem_we, 0);
    chk("st_resp_valid", a_resp_valid, 1);
    chk("st_resp_rdata", a_resp_rdata, 0);
    chk("st_resp_err", a_resp_err, 0);
    chk("st_mem5", mem_a[5], 16'hBEEF);
    chk("st_one_write", a_wr_cnt, 1);
    tick;
    chk("st_done_valid", a_resp_valid, 0);
    chk("st_done_ready", a_req_ready, 1);

    // Word load of word 5
    a_issue(0, wa(16'd5), 16'h0, 0, 0);
    chk("ld_re", a_mem_re, 1);
    chk("ld_addr", a_mem_address, 16'd5);
    chk("ld_no_resp_yet", a_resp_valid, 0);
    tick;
    chk("ld_resp_valid", a_resp_valid, 1);
    chk("ld_rdata", a_resp_rdata, 16'hBEEF);
    chk("ld_re_drop", a_mem_re, 0);
    chk("ld_one_read", a_rd_cnt, 1);
    tick;

    // Highest legal word
    a_issue(1, wa(16'd511), 16'h5A5A, 0, 0); tick; tick;
    a_issue(0, wa(16'd511), 16'h0, 0, 0); tick;
    chk("ld511_rdata", a_resp_rdata, 16'h5A5A);
    chk("ld511_err", a_resp_err, 0);
    tick;

    // Out-of-range load and store
    wr0 = a_wr_cnt; rd0 = a_rd_cnt;
    a_issue(0, wa(16'd512), 16'h0, 0, 0);
    chk("err_ld_valid", a_resp_valid, 1);
    chk("err_ld_err", a_resp_err, 1);
    chk("err_ld_rdata", a_resp_rdata, 0);
    chk("err_ld_strobes", {a_mem_we, a_mem_re}, 0);
    tick;
    chk("err_ld_idle", a_req_ready, 1);
    a_issue(1, wa(16'h7FFF), 16'hFFFF, 0, 0);
    chk("err_st_err", a_resp_err, 1);
    chk("err_st_we", a_mem_we, 0);
    tick;
    chk("err_no_writes", a_wr_cnt, wr0);
    chk("err_no_reads", a_rd_cnt, rd0);

    // Backpressure: hold response for 4 cycles
    a_issue(1, wa(16'd9), 16'h1234, 0, 0); tick; tick;
    a_resp_ready = 0;
    a_issue(0, wa(16'd9), 16'h0, 0, 0); tick;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", a_resp_valid, 1);
      chk("bp_rdata", a_resp_rdata, 16'h1234);
      chk("bp_req_ready", a_req_ready, 0);
      tick;
    end
    a_resp_ready = 1;
    tick;
    chk("bp_release_valid", a_resp_valid, 0);
    chk("bp_release_ready", a_req_ready, 1);

`ifdef BYTE_ACCESS_EN
    // Byte read-modify-write and byte loads
    a_issue(1, 16'd6, 16'h12F0, 0, 0); tick; tick;
    a_issue(1, 16'd7, 16'h00AB, 1, 0);
    chk("bst_re", a_mem_re, 1);
    chk("bst_addr", a_mem_address, 16'd3);
    chk("bst_no_we", a_mem_we, 0);
    tick;
    chk("bst_we", a_mem_we, 1);
    chk("bst_merge", a_mem_write_data, 16'hABF0);
    tick;
    chk("bst_resp", a_resp_valid, 1);
    chk("bst_mem3", mem_a[3], 16'hABF0);
    tick;
    a_issue(0, 16'd6, 16'h0, 1, 1); tick;
    chk("bld_signed_lo", a_resp_rdata, 16'hFFF0);
    tick;
    a_issue(0, 16'd6, 16'h0, 1, 0); tick;
    chk("bld_unsigned_lo", a_resp_rdata, 16'h00F0);
    tick;
    a_issue(0, 16'd7, 16'h0, 1, 1); tick;
    chk("bld_signed_hi", a_resp_rdata, 16'hFFAB);
    tick;
    rd0 = a_rd_cnt;
    a_issue(0, 16'd9, 16'h0, 0, 0);
    chk("odd_word_err", a_resp_err, 1);
    chk("odd_word_strobes", {a_mem_we, a_mem_re}, 0);
    tick;
    chk("odd_word_no_read", a_rd_cnt, rd0);
`else
    // Byte controls are ignored: store goes straight to WRITE
    a_issue(1, 16'd7, 16'hABCD, 1, 1);
    chk("wm_we", a_mem_we, 1);
    chk("wm_wdata", a_mem_write_data, 16'hABCD);
    chk("wm_no_re", a_mem_re, 0);
    tick; tick;
    a_issue(0, 16'd7, 16'h0, 1, 1); tick;
    chk("wm_ld", a_resp_rdata, 16'hABCD);
    tick;
`endif

    // Instance b: READ_LATENCY = 3
    b_issue(1, wa(16'd2), 16'h7777); tick; tick;
    b_issue(0, wa(16'd2), 16'h0);
    chk("l3_re0", b_mem_re, 1);
    tick;
    chk("l3_re1", b_mem_re, 1);
    chk("l3_wait1", b_resp_valid, 0);
    tick;
    chk("l3_wait2", b_resp_valid, 0);
    tick;
    chk("l3_valid", b_resp_valid, 1);
    chk("l3_rdata", b_resp_rdata, 16'h7777);
    chk("l3_reads", b_rd_cnt, 3);
    tick;

    // Reset while in READ
    b_issue(0, wa(16'd2), 16'h0);
    tick;
    b_rst = 1'b1;
    #1;
    chk("rr_re_forced", b_mem_re, 0);
    tick;
    chk("rr_req_ready", b_req_ready, 1);
    chk("rr_resp_valid", b_resp_valid, 0);
    chk("rr_mem_out", {b_mem_address, b_mem_write_data, b_mem_we, b_mem_re}, 0);
    chk("rr_resp_out", {b_resp_rdata, b_resp_err}, 0);
    b_rst = 1'b0;
    wr0 = b_wr_cnt;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rr_no_resp", b_resp_valid, 0);
    end
    chk("rr_no_write", b_wr_cnt, wr0);

    // Reset during WRITE: the store must not complete
    b_issue(1, wa(16'd2), 16'h0F0F);
    chk("rw_we_before", b_mem_we, 1);
    b_rst = 1'b1;
    #1;
    chk("rw_we_forced", b_mem_we, 0);
    tick;
    b_rst = 1'b0;
    chk("rw_mem_kept", mem_b[2], 16'h7777);
    chk("rw_no_write", b_wr_cnt, wr0);
    chk("rw_idle", b_req_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
